// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a grant is also the accept, since a grant
// is only issued to a valid requester.
//
// last_gnt | meaning
// WB_ALU   | input 0 was served last, input 1 wins the next tie
// WB_LSU   | input 1 was served last, input 0 wins the next tie
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    import regfile_pkg::*;

    wb_src_t last_gnt;
    wb_src_t last_gnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= WB_LSU;
        end else begin
            last_gnt <= last_gnt_nxt;
        end
    end

    // Grants are held low while reset is asserted.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        last_gnt_nxt = last_gnt;
        if (rst) begin
            if (req0 && (!req1 || last_gnt == WB_LSU)) begin
                gnt0         = 1'b1;
                last_gnt_nxt = WB_ALU;
            end else if (req1) begin
                gnt1         = 1'b1;
                last_gnt_nxt = WB_LSU;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file write-port arbiter (ALU vs load unit) with busy scoreboard.
// Optional REGFILE_WB_BYPASS_EN adds fwd1/fwd2/fwd_data forwarding outputs.
module regfile_wb_arb #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int DATA_W   = regfile_pkg::DATA_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] alu_wa,
    input  logic [DATA_W-1:0]                 alu_wd,
    input  logic                              lsu_valid,
    output logic                              lsu_ready,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] lsu_wa,
    input  logic [DATA_W-1:0]                 lsu_wd,
    input  logic                              rsv_en,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] rsv_addr,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] ra1,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] ra2,
    output logic                              busy1,
    output logic                              busy2,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                              fwd1,
    output logic                              fwd2,
    output logic [DATA_W-1:0]                 fwd_data,
`endif
    output logic                              sb_conflict,
    output logic                              writeReg,
    output logic [regfile_pkg::REG_ADDR_W-1:0] wa,
    output logic [DATA_W-1:0]                 wd
);
    import regfile_pkg::*;

    logic                  gnt_alu;
    logic                  gnt_lsu;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_wa;
    logic [DATA_W-1:0]     sel_wd;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  rsv_live;
    logic                  conflict_nxt;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (alu_valid),
        .req1 (lsu_valid),
        .gnt0 (gnt_alu),
        .gnt1 (gnt_lsu)
    );

    assign alu_ready = gnt_alu;
    assign lsu_ready = gnt_lsu;
    assign accept    = gnt_alu | gnt_lsu;
    assign sel_wa    = gnt_alu ? alu_wa : lsu_wa;
    assign sel_wd    = gnt_alu ? alu_wd : lsu_wd;

    // Writes to $0 are handshaken away without touching the port or the
    // scoreboard, so wa/wd keep the last real write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeReg <= 1'b0;
            wa       <= ZERO_REG;
            wd       <= '0;
        end else begin
            writeReg <= accept && (sel_wa != ZERO_REG);
            if (accept && (sel_wa != ZERO_REG)) begin
                wa <= sel_wa;
                wd <= sel_wd;
            end
        end
    end

    assign rsv_live = rsv_en && (rsv_addr != ZERO_REG);

    // A register whose producer completes this same cycle is free to re-reserve.
    assign conflict_nxt = rsv_live && busy[rsv_addr] && !(writeReg && (wa == rsv_addr));

    always_comb begin
        busy_nxt = busy;
        if (writeReg) begin
            busy_nxt[wa] = 1'b0;
        end
        if (rsv_live) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            sb_conflict <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            sb_conflict <= conflict_nxt;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd1     = writeReg && (wa == ra1) && (ra1 != ZERO_REG);
    assign fwd2     = writeReg && (wa == ra2) && (ra2 != ZERO_REG);
    assign fwd_data = wd;
    assign busy1    = busy[ra1] & ~fwd1;
    assign busy2    = busy[ra2] & ~fwd2;
`else
    assign busy1    = busy[ra1];
    assign busy2    = busy[ra2];
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed vector bench for regfile_wb_arb (default and bypass builds).
module tb_regfile_wb_arb;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_wa;
    logic [31:0] lsu_wd;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        busy1;
    logic        busy2;
    logic        sb_conflict;
    logic        writeReg;
    logic [4:0]  wa;
    logic [31:0] wd;
`ifdef REGFILE_WB_BYPASS_EN
    logic        fwd1;
    logic        fwd2;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    regfile_wb_arb dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_wa      (alu_wa),
        .alu_wd      (alu_wd),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_wa      (lsu_wa),
        .lsu_wd      (lsu_wd),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy1       (busy1),
        .busy2       (busy2),
`ifdef REGFILE_WB_BYPASS_EN
        .fwd1        (fwd1),
        .fwd2        (fwd2),
        .fwd_data    (fwd_data),
`endif
        .sb_conflict (sb_conflict),
        .writeReg    (writeReg),
        .wa          (wa),
        .wd          (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  awa;
        logic [31:0] awd;
        logic        lv;
        logic [4:0]  lwa;
        logic [31:0] lwd;
        logic        ren;
        logic [4:0]  raddr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ar;
        logic        e_lr;
        logic        e_wr;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_b1;
        logic        e_b2;
        logic        e_cf;
        logic        chk_wad;
        logic        e_f1;
        logic        e_f2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] awa, input logic [31:0] awd,
        input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
        input logic ren, input logic [4:0] raddr,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic e_ar, input logic e_lr,
        input logic e_wr, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_b1, input logic e_b2, input logic e_cf,
        input logic chk_wad, input logic e_f1, input logic e_f2);
        vec_t v;
        v.av = av; v.awa = awa; v.awd = awd;
        v.lv = lv; v.lwa = lwa; v.lwd = lwd;
        v.ren = ren; v.raddr = raddr; v.r1 = r1; v.r2 = r2;
        v.e_ar = e_ar; v.e_lr = e_lr;
        v.e_wr = e_wr; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_cf = e_cf;
        v.chk_wad = chk_wad; v.e_f1 = e_f1; v.e_f2 = e_f2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
        lsu_valid = 1'b0; lsu_wa = '0; lsu_wd = '0;
        rsv_en = 1'b0; rsv_addr = '0; ra1 = '0; ra2 = '0;
    endtask

    initial begin
        // Each row: inputs for the cycle; expected readies for that cycle and
        // registered outputs / busy as seen during that cycle.
        //         av awa  awd           lv lwa  lwd          ren ra  r1 r2  ar lr wr wa  wd            b1 b2 cf cw f1 f2
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,      0, 0, 0, 0,  1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 0,  0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 0,  0, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 6, 32'h66,     0, 0, 0, 0,  0, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h11,       1, 9, 32'h99,     0, 0, 0, 0,  1, 0, 1, 6, 32'h66,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 32'h22,       1, 9, 32'h99,     0, 0, 0, 0,  0, 1, 1, 1, 32'h11,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 32'h22,       1, 10, 32'h1010,  0, 0, 0, 0,  1, 0, 1, 9, 32'h99,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3, 32'h3333,     1, 10, 32'h1010,  0, 0, 0, 0,  0, 1, 1, 2, 32'h22,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 0,  0, 0, 1, 10, 32'h1010,    0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 0,  0, 0, 0, 10, 32'h1010,    0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      1, 7, 7, 0,  0, 0, 0, 10, 32'h1010,    0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 7, 32'h77,     0, 0, 7, 0,  0, 1, 0, 10, 32'h1010,    1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 7, 0,  0, 0, 1, 7, 32'h77,       !BYP, 0, 0, 1, BYP, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 7, 0,  0, 0, 0, 7, 32'h77,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3, 32'h33,       0, 0, 32'h0,      0, 0, 0, 3,  1, 0, 0, 7, 32'h77,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      1, 3, 0, 3,  0, 0, 1, 3, 32'h33,       0, 0, 0, 1, 0, BYP));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 3,  0, 0, 0, 3, 32'h33,       0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      1, 3, 0, 3,  0, 0, 0, 3, 32'h33,       0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 3,  0, 0, 0, 3, 32'h33,       0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 3,  0, 0, 0, 3, 32'h33,       0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h1234,     0, 0, 32'h0,      1, 0, 0, 0,  1, 0, 0, 3, 32'h33,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 0,  0, 0, 0, 3, 32'h33,       0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4, 32'h44,       1, 12, 32'hCC,    0, 0, 0, 0,  0, 1, 0, 3, 32'h33,       0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,      0, 0, 0, 0,  0, 0, 1, 12, 32'hCC,      0, 0, 0, 1, 0, 0));

        // Reset state, with a requester already valid.
        idle_inputs();
        rst = 1'b0;
        alu_valid = 1'b1; alu_wa = 5'd5;
        #2;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_writeReg", writeReg, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_conflict", sb_conflict, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            alu_valid = vecs[i].av; alu_wa = vecs[i].awa; alu_wd = vecs[i].awd;
            lsu_valid = vecs[i].lv; lsu_wa = vecs[i].lwa; lsu_wd = vecs[i].lwd;
            rsv_en = vecs[i].ren; rsv_addr = vecs[i].raddr;
            ra1 = vecs[i].r1; ra2 = vecs[i].r2;
            #1;
            check($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            check($sformatf("v%0d_lsu_ready", i), lsu_ready, vecs[i].e_lr);
            check($sformatf("v%0d_writeReg", i), writeReg, vecs[i].e_wr);
            if (vecs[i].chk_wad) begin
                check($sformatf("v%0d_wa", i), wa, vecs[i].e_wa);
                check($sformatf("v%0d_wd", i), wd, vecs[i].e_wd);
            end
            check($sformatf("v%0d_busy1", i), busy1, vecs[i].e_b1);
            check($sformatf("v%0d_busy2", i), busy2, vecs[i].e_b2);
            check($sformatf("v%0d_conflict", i), sb_conflict, vecs[i].e_cf);
`ifdef REGFILE_WB_BYPASS_EN
            check($sformatf("v%0d_fwd1", i), fwd1, vecs[i].e_f1);
            check($sformatf("v%0d_fwd2", i), fwd2, vecs[i].e_f2);
            if (vecs[i].e_f1 || vecs[i].e_f2)
                check($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_wd);
`endif
        end

        // Reset mid-operation: reserve r8 twice, accept an ALU write to r8,
        // then drop reset before the register file commits it.
        @(posedge clk); #1;
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd8; ra1 = 5'd8; ra2 = 5'd3;
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_wa = 5'd8; alu_wd = 32'h88;
        #1;
        check("mid_alu_ready", alu_ready, 1);
        check("mid_busy1", busy1, 1);
        check("mid_busy2", busy2, 1);
        @(posedge clk); #1;
        rsv_en = 1'b0;
        lsu_valid = 1'b1; lsu_wa = 5'd12; lsu_wd = 32'hC0C0;
        check("mid_writeReg", writeReg, 1);
        check("mid_conflict", sb_conflict, 1);
        rst = 1'b0;
        #1;
        check("arst_writeReg", writeReg, 0);
        check("arst_wa", wa, 0);
        check("arst_wd", wd, 0);
        check("arst_conflict", sb_conflict, 0);
        check("arst_busy1", busy1, 0);
        check("arst_busy2", busy2, 0);
        check("arst_alu_ready", alu_ready, 0);
        check("arst_lsu_ready", lsu_ready, 0);
        #1;
        rst = 1'b1;
        #1;
        check("rel_alu_ready", alu_ready, 1);
        check("rel_lsu_ready", lsu_ready, 0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("rel_writeReg", writeReg, 1);
        check("rel_wa", wa, 8);
        check("rel_wd", wd, 32'h88);
        @(posedge clk); #1;
        check("rel_writeReg_off", writeReg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-port arbiter and scoreboard for the 32×32 register file. Two writeback requesters (ALU and load unit) compete for the single register-file write port through valid/ready handshakes, with round-robin arbitration. A 32-bit busy scoreboard, filled by the issue stage and drained by completed writebacks, tells the decoder when a source register is still pending. The block sits between the execute/memory stages and the register file, and drives the file's `writeReg`/`wa`/`wd` inputs.

## Interface
- `NUM_REGS`, 32: register count; the scoreboard width.
- `DATA_W`, 32: writeback data width.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `alu_valid` / `alu_ready` in/out 1: ALU writeback handshake.
- `alu_wa` in 5, `alu_wd` in DATA_W: ALU destination register and data.
- `lsu_valid` / `lsu_ready` in/out 1: load-unit writeback handshake.
- `lsu_wa` in 5, `lsu_wd` in DATA_W: load-unit destination register and data.
- `rsv_en` in 1, `rsv_addr` in 5: issue stage marks `rsv_addr` as pending.
- `ra1`, `ra2` in 5: decoder source addresses.
- `busy1`, `busy2` out 1: scoreboard state of `ra1`/`ra2`; combinational.
- `sb_conflict` out 1: registered; one-cycle pulse when reserving an already-busy register.
- `writeReg` out 1, `wa` out 5, `wd` out DATA_W: register-file write port; registered.

## Operation
- Arbitration is combinational from the `*_valid` inputs and `last_gnt`.
  - Exactly one requester valid: that requester is granted.
  - Both valid: grant the one not granted last time.
  - `alu_ready` = ALU grant; `lsu_ready` = LSU grant. A ready is never asserted without its matching valid.
- Accept (valid & ready at posedge):
  - Capture the granted `wa`/`wd` into the output register and set `writeReg`.
  - Update `last_gnt`.
- No accept: `writeReg` is 0 the next cycle, and `wa`/`wd` hold their last values.
- A request to `$0` is accepted (ready given), but `writeReg` stays 0 and no scoreboard change occurs.
- Scoreboard, evaluated at each posedge:
  - Clear: `busy[wa]` is cleared when `writeReg` is 1 in the ending cycle.
  - Set: `busy[rsv_addr]` is set when `rsv_en` is 1.
  - Same register set and cleared in the same cycle: set wins (a new producer has been issued).
  - Reserving `$0` is ignored; `busy[0]` is permanently 0.
  - `rsv_en` to an already-busy register: the bit stays 1 and `sb_conflict` pulses next cycle. Only one in-flight write per register is tracked.
- `busy1 = busy[ra1]`, `busy2 = busy[ra2]`.

## Timing
- Accept in cycle N → `writeReg`/`wa`/`wd` valid throughout cycle N+1. The register file commits on the negedge inside N+1.
- The busy bit clears at the posedge ending N+1. Reads in cycle N+2 see both the new data and busy = 0.
- Sustained throughput: one write per cycle. With both requesters continuously valid, grants alternate ALU, LSU, ALU, …
- Reset values (asynchronous, while `rst` = 0):
  - Outputs: `writeReg` = 0, `wa` = 0, `wd` = 0, `sb_conflict` = 0.
  - State: `busy` = 0, `last_gnt` = LSU, so the ALU wins the first tie.
  - `alu_ready` = `lsu_ready` = 0 while reset is asserted.
- Reset mid-operation: an accepted but not yet presented write is dropped, and all busy bits clear. Requesters must re-issue.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - Adds outputs `fwd1`, `fwd2` (1 bit) and `fwd_data` (DATA_W).
  - `fwdK` = `writeReg & (wa == raK) & (raK != 0)`; `fwd_data` = `wd`.
  - `busyK` is forced to 0 when `fwdK` = 1, so the decoder takes the forwarded value in cycle N+1 instead of stalling until N+2.
- Undefined: the ports are absent, and `busyK` follows the scoreboard bit exactly.

## Structure
- Shared package `regfile_pkg`:
  - Constants `REG_ADDR_W` = 5, `NUM_REGS` = 32, `DATA_W` = 32, `ZERO_REG` = 5'd0.
  - Enum `wb_src_t` {`WB_ALU`, `WB_LSU`} for `last_gnt`.
- Sub-module `rr_arb2`: two-input round-robin arbiter with a `last_gnt` register. It is reusable for the memory-port arbiter.

## Test plan
- Reset, then ALU writes r5 = 0xDEADBEEF → `alu_ready` = 1 in the same cycle; next cycle `writeReg` = 1, `wa` = 5, `wd` = 0xDEADBEEF; the following cycle `writeReg` = 0.
- ALU and LSU both valid for 4 cycles (r1..r4 / r9..r12) → grant order ALU r1, LSU r9, ALU r2, LSU r10; each loser holds valid and is served next.
- `rsv_en` r7, `ra1` = 7 → `busy1` = 1 from the next cycle; LSU writes r7 → `busy1` stays 1 through the `writeReg` cycle and reads 0 one cycle later (0 during `writeReg` with bypass enabled, with `fwd1` = 1).
- Same cycle: `writeReg` to r3 and `rsv_en` r3 → r3 remains busy; a separate `rsv_en` r3 while busy → `sb_conflict` pulses once.
- ALU writes `$0` = 0x1234 and `rsv_en` r0 → `alu_ready` = 1, `writeReg` stays 0, `busy` for r0 stays 0.
- Accept r8, then drop `rst` to 0 mid-cycle before the write is presented → `writeReg`, `busy`, `sb_conflict` and the readies go to 0 immediately; after release the first tie is granted to the ALU.
